// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer for a single-ported data memory with a fixed
// read latency, one-cycle acks, and a halt path that drains, dumps once and parks.
module dmem_arbiter #(
   parameter int N      = 32,
   parameter int RD_LAT = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0,
   input  logic         wr0,
   input  logic [N-1:0] addr0,
   input  logic [N-1:0] wdata0,
   input  logic         req1,
   input  logic         wr1,
   input  logic [N-1:0] addr1,
   input  logic [N-1:0] wdata1,
   output logic         ack0,
   output logic         ack1,
   output logic [N-1:0] rdata0,
   output logic [N-1:0] rdata1,
   input  logic         halt,
   output logic         mem_en,
   output logic         mem_wr,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata,
   output logic         mem_dump,
   output logic         busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      RESP   = 3'd3,
      DUMP   = 3'd4,
      HALTED = 3'd5
   } state_t;

   localparam logic [3:0] LAT = 4'(RD_LAT);

   state_t       state_q, state_d;
   logic         halt_pend_q, halt_pend_d;
   logic         last_grant_q, last_grant_d;
   logic         owner_q, owner_d;
   logic         wr_q, wr_d;
   logic [N-1:0] addr_q, addr_d;
   logic [N-1:0] wdata_q, wdata_d;
   logic [3:0]   cnt_q, cnt_d;
   logic [N-1:0] rdata0_q, rdata0_d;
   logic [N-1:0] rdata1_q, rdata1_d;
   logic         ack0_q, ack0_d;
   logic         ack1_q, ack1_d;
   logic         mem_en_q, mem_en_d;
   logic         mem_wr_q, mem_wr_d;
   logic         mem_dump_q, mem_dump_d;
   logic         busy_q, busy_d;
   logic         grant_s;
   logic         capture_s;

   // Round-robin pick: on contention the port not granted last time wins.
   always_comb begin
      grant_s = 1'b0;
      if (req0 && req1) begin
         grant_s = ~last_grant_q;
      end else if (req0) begin
         grant_s = 1'b0;
      end else begin
         grant_s = 1'b1;
      end
   end

   // Next-state, latching and load-capture logic.
   always_comb begin
      state_d      = state_q;
      halt_pend_d  = halt_pend_q | halt;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      capture_s    = 1'b0;

      case (state_q)
         IDLE: begin
            // A halt seen this very cycle already beats a simultaneous request.
            if (halt_pend_q || halt) begin
               state_d = DUMP;
            end else if (req0 || req1) begin
               owner_d = grant_s;
               wr_d    = grant_s ? wr1 : wr0;
               addr_d  = grant_s ? addr1 : addr0;
               wdata_d = grant_s ? wdata1 : wdata0;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            if (LAT == 4'd0) begin
               capture_s = 1'b1;
               state_d   = RESP;
            end else begin
               cnt_d   = LAT;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               capture_s = 1'b1;
               state_d   = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            last_grant_d = owner_q;
            state_d      = IDLE;
         end
         DUMP:    state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = IDLE;
      endcase

      if (capture_s && !wr_q) begin
         if (owner_q) begin
            rdata1_d = mem_rdata;
         end else begin
            rdata0_d = mem_rdata;
         end
      end else begin
         rdata0_d = rdata0_d;
      end
   end

   // Outputs are decoded from the next state so they leave the block registered.
   always_comb begin
      ack0_d     = (state_d == RESP) && !owner_d;
      ack1_d     = (state_d == RESP) && owner_d;
      mem_en_d   = (state_d == ISSUE);
      mem_wr_d   = (state_d == ISSUE) && wr_d;
      mem_dump_d = (state_d == DUMP);
      busy_d     = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         halt_pend_q  <= 1'b0;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         wr_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= 4'd0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         mem_en_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_dump_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         halt_pend_q  <= halt_pend_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         mem_en_q     <= mem_en_d;
         mem_wr_q     <= mem_wr_d;
         mem_dump_q   <= mem_dump_d;
         busy_q       <= busy_d;
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_dump  = mem_dump_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench: instance A uses RD_LAT=0, instance B uses RD_LAT=2; the
// instance not under test is held in reset and sel picks whose outputs are observed.
module tb_dmem_arbiter;

   typedef struct {
      int          port;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_na, rst_nb, sel;
   logic        req0, wr0, req1, wr1, halt;
   logic [31:0] addr0, wdata0, addr1, wdata1;

   logic        ack0_a, ack1_a, mem_en_a, mem_wr_a, mem_dump_a, busy_a;
   logic [31:0] rdata0_a, rdata1_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
   logic        ack0_b, ack1_b, mem_en_b, mem_wr_b, mem_dump_b, busy_b;
   logic [31:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

   logic        ack0, ack1, mem_en, mem_wr, mem_dump, busy;
   logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;

   exp_t        sb[$];
   logic [31:0] exp_rd [2];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] memb [logic [31:0]];
   logic        p1_v = 1'b0, p2_v = 1'b0;
   logic [31:0] p1_d = 32'd0, p2_d = 32'd0;

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return 32'hDEADBEEF + (a - 32'h10);
   endfunction

   dmem_arbiter #(.N(32), .RD_LAT(0)) dut_a (
      .clk(clk), .rst_n(rst_na),
      .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
      .ack0(ack0_a), .ack1(ack1_a), .rdata0(rdata0_a), .rdata1(rdata1_a),
      .halt(halt), .mem_en(mem_en_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .mem_dump(mem_dump_a), .busy(busy_a));

   dmem_arbiter #(.N(32), .RD_LAT(2)) dut_b (
      .clk(clk), .rst_n(rst_nb),
      .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
      .ack0(ack0_b), .ack1(ack1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
      .halt(halt), .mem_en(mem_en_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .mem_dump(mem_dump_b), .busy(busy_b));

   // Zero-latency memory returns a pattern only during a read issue cycle.
   assign mem_rdata_a = (mem_en_a && !mem_wr_a) ? pat(mem_addr_a) : 32'hBAD0BAD0;

   // Two-cycle memory: data valid exactly two cycles after the read issue cycle.
   always @(posedge clk) begin
      p1_v <= mem_en_b && !mem_wr_b;
      p1_d <= memb.exists(mem_addr_b) ? memb[mem_addr_b] : pat(mem_addr_b);
      p2_v <= p1_v;
      p2_d <= p1_d;
      if (mem_en_b && mem_wr_b) memb[mem_addr_b] = mem_wdata_b;
   end
   assign mem_rdata_b = p2_v ? p2_d : 32'hBAD0BAD0;

   assign ack0      = sel ? ack0_b      : ack0_a;
   assign ack1      = sel ? ack1_b      : ack1_a;
   assign rdata0    = sel ? rdata0_b    : rdata0_a;
   assign rdata1    = sel ? rdata1_b    : rdata1_a;
   assign mem_en    = sel ? mem_en_b    : mem_en_a;
   assign mem_wr    = sel ? mem_wr_b    : mem_wr_a;
   assign mem_addr  = sel ? mem_addr_b  : mem_addr_a;
   assign mem_wdata = sel ? mem_wdata_b : mem_wdata_a;
   assign mem_dump  = sel ? mem_dump_b  : mem_dump_a;
   assign busy      = sel ? busy_b      : busy_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input int port, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] ld_val);
      exp_t e;
      if (!wr) exp_rd[port] = ld_val;
      e.port = port; e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = exp_rd[port];
      sb.push_back(e);
   endtask

   task automatic do_reset(input logic which);
      rst_na = 1'b0; rst_nb = 1'b0; sel = which;
      req0 = 1'b0; wr0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
      req1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0; halt = 1'b0;
      sb.delete(); exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
      repeat (2) @(negedge clk);
      if (which) rst_nb = 1'b1; else rst_na = 1'b1;
   endtask

   // Waits (bounded) for the next ack, checking issue fields against the scoreboard head.
   task automatic run_until_ack(input int max, input int exp_en, output int port, output int cyc);
      exp_t e;
      int   en_cnt = 0;
      port = -1; cyc = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         cyc++;
         if (mem_en && sb.size() > 0) begin
            en_cnt++;
            chk("mem_addr", mem_addr, sb[0].addr);
            chk("mem_wr", 32'(mem_wr), 32'(sb[0].wr));
            if (sb[0].wr) chk("mem_wdata", mem_wdata, sb[0].wdata);
         end
         if (ack0 || ack1) begin
            port = ack1 ? 1 : 0;
            chk("ack_onehot", 32'(ack0 & ack1), 32'd0);
            break;
         end
      end
      if (port < 0) begin
         chk("ack_timeout", 32'(cyc), 32'(max + 1));
      end else if (sb.size() == 0) begin
         chk("unexpected_ack", 32'(port), 32'hFFFFFFFF);
      end else begin
         e = sb.pop_front();
         chk("ack_port", 32'(port), 32'(e.port));
         chk("rdata", port == 1 ? rdata1 : rdata0, e.rdata);
         chk("issue_count", 32'(en_cnt), 32'(exp_en));
      end
   endtask

   initial begin
      int port, cyc, acks, ens, dumps, idles;

      // Reset values and single load with RD_LAT=0
      do_reset(1'b0);
      @(negedge clk);
      chk("rst_ack0", 32'(ack0), 32'd0);
      chk("rst_ack1", 32'(ack1), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_wr", 32'(mem_wr), 32'd0);
      chk("rst_mem_dump", 32'(mem_dump), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata0", rdata0, 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);

      req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h10;
      push(0, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_mem_en", 32'(mem_en), 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h10);
      run_until_ack(8, 0, port, cyc);
      chk("t1_ack_lat", 32'(cyc), 32'd1);
      req0 = 1'b0;
      @(negedge clk);
      chk("t1_busy_low", 32'(busy), 32'd0);

      // Contention: both held, new fields after each ack, grants alternate
      do_reset(1'b0);
      req0 = 1'b1; addr0 = 32'h100; req1 = 1'b1; addr1 = 32'h200;
      push(0, 1'b0, 32'h100, 32'd0, pat(32'h100));
      push(1, 1'b0, 32'h200, 32'd0, pat(32'h200));
      for (int k = 0; k < 4; k++) begin
         run_until_ack(10, 1, port, cyc);
         chk("cont_order", 32'(port), 32'(k % 2));
         chk("cont_spacing", 32'(cyc), (k == 0) ? 32'd2 : 32'd3);
         if (k < 2) begin
            if (port == 0) begin
               addr0 = 32'h104; push(0, 1'b0, 32'h104, 32'd0, pat(32'h104));
            end else begin
               addr1 = 32'h204; push(1, 1'b0, 32'h204, 32'd0, pat(32'h204));
            end
         end else begin
            if (port == 0) req0 = 1'b0; else req1 = 1'b0;
         end
      end

      // Store then load on port 1 with RD_LAT=2
      do_reset(1'b1);
      @(negedge clk);
      req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h20; wdata1 = 32'hCAFEF00D;
      push(1, 1'b1, 32'h20, 32'hCAFEF00D, 32'd0);
      run_until_ack(12, 1, port, cyc);
      chk("st_ack_lat", 32'(cyc), 32'd4);
      req1 = 1'b0;
      @(negedge clk);
      req1 = 1'b1; wr1 = 1'b0; wdata1 = 32'd0;
      push(1, 1'b0, 32'h20, 32'd0, 32'hCAFEF00D);
      run_until_ack(12, 1, port, cyc);
      chk("ld_ack_lat", 32'(cyc), 32'd4);
      req1 = 1'b0;

      // Halt pulse during WAIT: drain, single dump, park
      @(negedge clk);
      req0 = 1'b1; wr0 = 1'b0; addr0 = 32'h30;
      push(0, 1'b0, 32'h30, 32'd0, pat(32'h30));
      @(negedge clk);
      @(negedge clk);
      halt = 1'b1; req1 = 1'b1; addr1 = 32'h34;
      @(negedge clk);
      halt = 1'b0;
      run_until_ack(8, 0, port, cyc);
      chk("halt_drain_lat", 32'(cyc), 32'd1);
      @(negedge clk);
      chk("halt_idle_dump", 32'(mem_dump), 32'd0);
      @(negedge clk);
      chk("halt_dump", 32'(mem_dump), 32'd1);
      chk("halt_busy", 32'(busy), 32'd1);
      acks = 0; ens = 0; dumps = 0; idles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ack0 || ack1) acks++;
         if (mem_en) ens++;
         if (mem_dump) dumps++;
         if (!busy) idles++;
      end
      chk("halted_acks", 32'(acks), 32'd0);
      chk("halted_mem_en", 32'(ens), 32'd0);
      chk("halted_dumps", 32'(dumps), 32'd0);
      chk("halted_not_busy", 32'(idles), 32'd0);
      chk("halt_sb_empty", 32'(sb.size()), 32'd0);

      // Async reset during WAIT, then first contention goes to port 0
      do_reset(1'b1);
      @(negedge clk);
      req0 = 1'b1; addr0 = 32'h40;
      @(negedge clk);
      chk("ar_issue", 32'(mem_en), 32'd1);
      @(negedge clk);
      #2 rst_nb = 1'b0;
      #1;
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_ack0", 32'(ack0), 32'd0);
      chk("ar_mem_addr", mem_addr, 32'd0);
      req0 = 1'b0;
      @(negedge clk);
      chk("ar_no_ack", 32'(ack0 | ack1), 32'd0);
      rst_nb = 1'b1;
      req0 = 1'b1; addr0 = 32'h50; req1 = 1'b1; addr1 = 32'h60;
      push(0, 1'b0, 32'h50, 32'd0, pat(32'h50));
      push(1, 1'b0, 32'h60, 32'd0, pat(32'h60));
      for (int k = 0; k < 2; k++) begin
         run_until_ack(12, 1, port, cyc);
         chk("ar_order", 32'(port), 32'(k));
         if (port == 0) req0 = 1'b0; else req1 = 1'b0;
      end
      chk("ar_ack_lat", 32'(cyc), 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
